// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module  : nibble_serial_adder (with cla, its 4-bit carry look-ahead slice)
// Brief   : WIDTH-bit adder that adds one nibble per clock through a single
//           CLA slice, with valid/ready handshakes on input and output.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [4:0] sum,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = {c[4], p ^ c[3:0]};
  assign cout = c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;

  logic [4:0]       cla_sum;
  logic             cla_cout;
  logic             cla_sum4_unused;

  cla u_cla (
    .a    (a_sh_q[3:0]),
    .b    (b_sh_q[3:0]),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  assign cla_sum4_unused = cla_sum[4];

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    partial_d   = partial_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;

    unique case (state_q)
      IDLE: begin
        // in_ready comes up one edge after reset release, then gates acceptance
        if (in_valid_i && in_ready_q) begin
          a_sh_d     = a_i;
          b_sh_d     = b_i;
          carry_d    = cin_i;
          a_msb_d    = a_i[WIDTH-1];
          b_msb_d    = b_i[WIDTH-1];
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      RUN: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (cnt_q == CW'(n)) partial_d[4*n +: 4] = cla_sum[3:0];
        end
        carry_d = cla_cout;
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NIBBLES - 1)) begin
          sum_d       = partial_d;
          cout_d      = cla_cout;
          ovf_d       = (a_msb_q == b_msb_q) && (partial_d[WIDTH-1] != a_msb_q);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready_i) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      partial_q   <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      partial_q   <= partial_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module  : tb_nibble_serial_adder
// Brief   : Self-checking bench for nibble_serial_adder (WIDTH=16 and WIDTH=4).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid16 = 1'b0, out_ready16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        in_ready16, out_valid16, cout16, ovf16;
  logic [15:0] sum16;

  logic        in_valid4 = 1'b0, out_ready4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        in_ready4, out_valid4, cout4, ovf4;
  logic [3:0]  sum4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid16), .in_ready_o(in_ready16),
    .a_i(a16), .b_i(b16), .cin_i(cin16),
    .out_valid_o(out_valid16), .out_ready_i(out_ready16),
    .sum_o(sum16), .cout_o(cout16), .ovf_o(ovf16)
  );

  nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .a_i(a4), .b_i(b4), .cin_i(cin4),
    .out_valid_o(out_valid4), .out_ready_i(out_ready4),
    .sum_o(sum4), .cout_o(cout4), .ovf_o(ovf4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model of the 16-bit instance: result = plain a+b+cin,
  // visible NIBBLES edges after acceptance, held until the output handshake.
  logic        m_ready, m_ov, m_co, m_of, p_co, p_of;
  logic [15:0] m_sum, p_sum;
  logic [16:0] m_full;
  int          m_left;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_in_ready", in_ready16, 0);
        chk("rst_out_valid", out_valid16, 0);
        chk("rst_sum", sum16, 0);
        chk("rst_cout_ovf", {cout16, ovf16}, 0);
        m_ready = 0; m_ov = 0; m_sum = '0; m_co = 0; m_of = 0; m_left = 0;
      end else begin
        chk("mdl_in_ready", in_ready16, m_ready);
        chk("mdl_out_valid", out_valid16, m_ov);
        chk("mdl_sum", sum16, m_sum);
        chk("mdl_cout", cout16, m_co);
        chk("mdl_ovf", ovf16, m_of);
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_ov = 1; m_sum = p_sum; m_co = p_co; m_of = p_of;
          end
        end else if (m_ov) begin
          if (out_ready16) begin m_ov = 0; m_ready = 1; end
        end else if (!m_ready) begin
          m_ready = 1;
        end else if (in_valid16) begin
          m_full = {1'b0, a16} + {1'b0, b16} + {16'd0, cin16};
          p_sum  = m_full[15:0];
          p_co   = m_full[16];
          p_of   = (a16[15] == b16[15]) && (p_sum[15] != a16[15]);
          m_ready = 0;
          m_left  = 4;
        end
      end
    end
  end

  task automatic wait_ready16();
    int k = 0;
    while (!in_ready16 && k < 20) begin @(negedge clk); k++; end
    chk("in_ready_wait", in_ready16, 1);
  endtask

  task automatic wait_result16(input string nm);
    int k = 0;
    while (!out_valid16 && k < 20) begin @(negedge clk); k++; end
    chk({nm, "_latency"}, k, 4);
  endtask

  task automatic op16(input string nm, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic [15:0] es, input logic eco, input logic eov);
    wait_ready16();
    a16 = a; b16 = b; cin16 = c; in_valid16 = 1;
    @(negedge clk);
    in_valid16 = 0;
    wait_result16(nm);
    chk({nm, "_sum"}, sum16, es);
    chk({nm, "_cout"}, cout16, eco);
    chk({nm, "_ovf"}, ovf16, eov);
    out_ready16 = 1;
    @(negedge clk);
    out_ready16 = 0;
    chk({nm, "_released"}, {in_ready16, out_valid16}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_sum16", sum16, 0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_first_edge", in_ready16, 1);

    op16("t1234", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    op16("tffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("t0fff", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
    op16("t7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op16("t8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Backpressure with new operands offered while the result is pending
    wait_ready16();
    a16 = 16'hA5A5; b16 = 16'h5A5A; cin16 = 1; in_valid16 = 1;
    @(negedge clk);
    in_valid16 = 0;
    wait_result16("bp");
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 0; in_valid16 = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_sum", sum16, 16'h0000);
      chk("bp_hold_flags", {out_valid16, in_ready16, cout16, ovf16}, 4'b1010);
    end
    out_ready16 = 1;
    @(negedge clk);
    out_ready16 = 0;
    chk("bp_release", {in_ready16, out_valid16}, 2'b10);
    @(negedge clk);
    in_valid16 = 0;
    wait_result16("bp_next");
    chk("bp_next_sum", sum16, 16'h3333);
    chk("bp_next_flags", {cout16, ovf16}, 2'b00);
    out_ready16 = 1;
    @(negedge clk);
    out_ready16 = 0;

    // Asynchronous reset after two nibbles of an operation
    wait_ready16();
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1; in_valid16 = 1;
    @(negedge clk);
    in_valid16 = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_outs", {in_ready16, out_valid16, cout16, ovf16}, 4'b0000);
    chk("async_rst_sum", sum16, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", {in_ready16, out_valid16}, 2'b10);
    op16("t00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // WIDTH=4 instance
    chk("w4_ready", in_ready4, 1);
    a4 = 4'hF; b4 = 4'h1; cin4 = 0; in_valid4 = 1;
    @(negedge clk);
    in_valid4 = 0;
    @(negedge clk);
    chk("w4_valid_1st_edge", out_valid4, 1);
    chk("w4_f1", {cout4, ovf4, sum4}, 6'b10_0000);
    out_ready4 = 1;
    @(negedge clk);
    out_ready4 = 0;
    chk("w4_release", {in_ready4, out_valid4}, 2'b10);
    a4 = 4'h7; b4 = 4'h1; cin4 = 0; in_valid4 = 1;
    @(negedge clk);
    in_valid4 = 0;
    @(negedge clk);
    chk("w4_71", {out_valid4, cout4, ovf4, sum4}, 7'b1_01_1000);
    out_ready4 = 1;
    @(negedge clk);
    out_ready4 = 0;

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
